// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: ALU control codes and FSM states.
package muldiv_pkg;

  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_DIV  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module muldiv_divstep #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    shifted   = {rem, quot[WIDTH-1]};
    diff      = shifted - {1'b0, divisor};
    // rem < divisor keeps shifted < 2*divisor, so the borrow bit alone decides the compare
    fits      = ~diff[WIDTH];
    rem_next  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quot_next = {quot[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed MULT/DIV unit with HI/LO registers for the execute stage.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational MULT; DIV stays iterative.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t state, state_next;

  logic [CW-1:0]      count;
  logic               op_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;

  logic               is_mul;
  logic               is_div;
  logic               accept;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_quot;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

`ifdef MULDIV_FAST_MUL_EN
  logic [WIDTH-1:0]   b_raw;
  logic [2*WIDTH-1:0] fast_prod;

  assign fast_prod = $signed({{WIDTH{a_raw[WIDTH-1]}}, a_raw}) *
                     $signed({{WIDTH{b_raw[WIDTH-1]}}, b_raw});
`endif

  assign is_mul = (alucontrol == ALU_MULT);
  assign is_div = (alucontrol == ALU_DIV);
  assign accept = (state == IDLE) && start && !flush && (is_mul || is_div);
  assign a_mag  = srca[WIDTH-1] ? -srca : srca;
  assign b_mag  = srcb[WIDTH-1] ? -srcb : srcb;
  assign busy   = (state != IDLE);

  // {acc_hi, acc_lo} is the shift-add product for MUL and {remainder, quotient} for DIV;
  // mcand holds the multiplicand or the divisor magnitude accordingly.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);

  muldiv_divstep #(
    .WIDTH(WIDTH)
  ) u_divstep (
    .rem      (acc_hi),
    .quot     (acc_lo),
    .divisor  (mcand),
    .rem_next (div_rem),
    .quot_next(div_quot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_div) begin
            state_next = DIV;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            state_next = FIX;
`else
            state_next = MUL;
`endif
          end
        end
      end
      MUL, DIV: begin
        if (flush) begin
          state_next = IDLE;
        end else if (count == '0) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    prod_mag = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod_mag : prod_mag;
`ifdef MULDIV_FAST_MUL_EN
    prod_fix = fast_prod;
`endif
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (op_div) begin
      if (div_zero) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_hi = neg_r ? -acc_hi : acc_hi;
        fix_lo = neg_q ? -acc_lo : acc_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      mcand    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      b_raw    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            count    <= CW'(WIDTH - 1);
            op_div   <= is_div;
            neg_q    <= srca[WIDTH-1] ^ srcb[WIDTH-1];
            neg_r    <= srca[WIDTH-1];
            div_zero <= (srcb == '0);
            a_raw    <= srca;
            acc_hi   <= '0;
            mcand    <= is_div ? b_mag : a_mag;
            acc_lo   <= is_div ? a_mag : b_mag;
`ifdef MULDIV_FAST_MUL_EN
            b_raw    <= srcb;
`endif
          end
        end
        MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          count  <= count - CW'(1);
        end
        DIV: begin
          acc_hi <= div_rem;
          acc_lo <= div_quot;
          count  <= count - CW'(1);
        end
        FIX: begin
          if (!flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus flush/reset/overlap sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  typedef struct {
    logic [3:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         flush;
  logic [3:0]   alucontrol;
  logic [W-1:0] srca;
  logic [W-1:0] srcb;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_hi;
  logic [W-1:0] prev_lo;
  vec_t vecs[14];

  always #5 clk = ~clk;

  muldiv_unit #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .alucontrol(alucontrol),
    .srca      (srca),
    .srcb      (srcb),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1; issues one op at the next edge (E0), then watches 80 cycles.
  task automatic run_op(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int flush_at, input int reset_at, input int restart_at,
                        input logic [3:0] rctl, input logic [W-1:0] ra, input logic [W-1:0] rb,
                        output int busy_n, output int done_n, output int done_cyc,
                        output int hold_bad);
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic         seen_done;
    eh = prev_hi;
    el = prev_lo;
    seen_done = 1'b0;
    busy_n = 0;
    done_n = 0;
    done_cyc = 0;
    hold_bad = 0;
    alucontrol = ctl;
    srca = a;
    srcb = b;
    start = 1'b1;
    flush = (flush_at == 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_cyc == 0) done_cyc = c;
        seen_done = 1'b1;
      end
      if (!seen_done && (hi !== eh || lo !== el)) hold_bad++;
      if (c == restart_at) begin
        alucontrol = rctl;
        srca = ra;
        srcb = rb;
        start = 1'b1;
      end
      flush = (c == flush_at);
      reset = (c == reset_at);
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      if (reset) begin
        reset = 1'b0;
        eh = '0;
        el = '0;
      end
    end
  endtask

  initial begin
    int bn, dn, dc, hb, eb;
    vecs[0]  = '{ALU_MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{ALU_DIV,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[2]  = '{ALU_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{ALU_DIV,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[4]  = '{ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[5]  = '{ALU_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[6]  = '{ALU_MULT, 32'd6,        32'd7,        32'd0,        32'd42};
    vecs[7]  = '{ALU_DIV,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2};
    vecs[8]  = '{ALU_DIV,  32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2};
    vecs[9]  = '{ALU_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};
    vecs[10] = '{ALU_MULT, 32'h12345678, 32'd16,       32'd1,        32'h23456780};
    vecs[11] = '{ALU_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[12] = '{ALU_MULT, 32'h7FFFFFFF, 32'd2,        32'd0,        32'hFFFFFFFE};
    vecs[13] = '{ALU_MULT, 32'd3,        32'd4,        32'd0,        32'd12};

    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    alucontrol = '0;
    srca = '0;
    srcb = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    prev_hi = '0;
    prev_lo = '0;

    for (int i = 0; i < 14; i++) begin
      eb = (vecs[i].ctl == ALU_MULT) ? MUL_BUSY : DIV_BUSY;
      run_op(vecs[i].ctl, vecs[i].a, vecs[i].b, -1, -1, -1, 4'd0, '0, '0, bn, dn, dc, hb);
      check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
      check($sformatf("vec%0d_busy_cycles", i), 64'(bn), 64'(eb));
      check($sformatf("vec%0d_done_pulses", i), 64'(dn), 64'd1);
      check($sformatf("vec%0d_done_cycle", i), 64'(dc), 64'(eb + 1));
      check($sformatf("vec%0d_hold", i), 64'(hb), 64'd0);
      prev_hi = vecs[i].hi;
      prev_lo = vecs[i].lo;
    end

    // DIV 9/2 squashed in cycle 10: hi/lo keep the 3x4 result
    run_op(ALU_DIV, 32'd9, 32'd2, 10, -1, -1, 4'd0, '0, '0, bn, dn, dc, hb);
    check("flush_busy_cycles", 64'(bn), 64'd10);
    check("flush_done_pulses", 64'(dn), 64'd0);
    check("flush_hi", 64'(hi), 64'd0);
    check("flush_lo", 64'(lo), 64'd12);
    check("flush_hold", 64'(hb), 64'd0);

    run_op(4'b0010, 32'd9, 32'd2, -1, -1, -1, 4'd0, '0, '0, bn, dn, dc, hb);
    check("badctl_busy_cycles", 64'(bn), 64'd0);
    check("badctl_done_pulses", 64'(dn), 64'd0);
    check("badctl_hold", 64'(hb), 64'd0);

    run_op(ALU_MULT, 32'd5, 32'd5, 0, -1, -1, 4'd0, '0, '0, bn, dn, dc, hb);
    check("idleflush_busy_cycles", 64'(bn), 64'd0);
    check("idleflush_done_pulses", 64'(dn), 64'd0);
    check("idleflush_hold", 64'(hb), 64'd0);

    // second start in cycle 5 while busy must be dropped
    run_op(ALU_DIV, 32'd100, 32'd7, -1, -1, 5, ALU_MULT, 32'd3, 32'd3, bn, dn, dc, hb);
    check("busystart_busy_cycles", 64'(bn), 64'd33);
    check("busystart_done_pulses", 64'(dn), 64'd1);
    check("busystart_hi", 64'(hi), 64'd2);
    check("busystart_lo", 64'(lo), 64'd14);
    check("busystart_hold", 64'(hb), 64'd0);
    prev_hi = 32'd2;
    prev_lo = 32'd14;

    // start in the done cycle is accepted; both results pulse done
    run_op(ALU_DIV, 32'hFFFFFF9C, 32'd7, -1, -1, 34, ALU_DIV, 32'd9, 32'd2, bn, dn, dc, hb);
    check("backtoback_busy_cycles", 64'(bn), 64'd66);
    check("backtoback_done_pulses", 64'(dn), 64'd2);
    check("backtoback_first_done", 64'(dc), 64'd34);
    check("backtoback_hi", 64'(hi), 64'd1);
    check("backtoback_lo", 64'(lo), 64'd4);
    check("backtoback_hold", 64'(hb), 64'd0);
    prev_hi = 32'd1;
    prev_lo = 32'd4;

    run_op(ALU_DIV, 32'd9, 32'd2, -1, 20, -1, 4'd0, '0, '0, bn, dn, dc, hb);
    check("midreset_busy_cycles", 64'(bn), 64'd20);
    check("midreset_done_pulses", 64'(dn), 64'd0);
    check("midreset_hi", 64'(hi), 64'd0);
    check("midreset_lo", 64'(lo), 64'd0);
    check("midreset_hold", 64'(hb), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
